// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined mux tree: select width, level count and pipeline latency.
package mux_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) r++;
    return r;
  endfunction

  // One register per REG_EVERY levels, rounding up because the last level is always registered.
  function automatic int latency_of(input int levels, input int reg_every);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  localparam int N_IN_DEFAULT      = 16;
  localparam int REG_EVERY_DEFAULT = 2;
  localparam int SEL_W             = clog2(N_IN_DEFAULT);
  localparam int LATENCY           = latency_of(SEL_W, REG_EVERY_DEFAULT);

endpackage

// File: rtl/mux_tree_level.sv
// One level of the mux tree: COUNT 2:1 muxes steered by bit BIT of the travelling tag,
// optionally registered and stalled by adv together with valid, tag and scan flag.
module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int COUNT      = 1,
  parameter int SEL_W      = 1,
  parameter int BIT        = 0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,
  input  logic                     valid_i,
  input  logic [SEL_W-1:0]         tag_i,
  input  logic                     scan_i,
  input  logic [2*COUNT*WIDTH-1:0] data_i,
  output logic                     valid_o,
  output logic [SEL_W-1:0]         tag_o,
  output logic                     scan_o,
  output logic [COUNT*WIDTH-1:0]   data_o
);

  logic [COUNT*WIDTH-1:0] mux_s;

  always_comb begin
    mux_s = '0;
    for (int k = 0; k < COUNT; k++) begin
      mux_s[k*WIDTH +: WIDTH] = tag_i[BIT] ? data_i[(2*k+1)*WIDTH +: WIDTH]
                                           : data_i[(2*k)*WIDTH +: WIDTH];
    end
  end

  generate
    if (REGISTERED) begin : g_reg
      logic                   valid_q, valid_d;
      logic                   scan_q, scan_d;
      logic [SEL_W-1:0]       tag_q, tag_d;
      logic [COUNT*WIDTH-1:0] data_q, data_d;

      always_comb begin
        valid_d = valid_q;
        scan_d  = scan_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (adv) begin
          valid_d = valid_i;
          scan_d  = scan_i;
          tag_d   = tag_i;
          data_d  = mux_s;
        end else begin
          valid_d = valid_q;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          scan_q  <= 1'b0;
          tag_q   <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          scan_q  <= scan_d;
          tag_q   <= tag_d;
          data_q  <= data_d;
        end
      end

      assign valid_o = valid_q;
      assign scan_o  = scan_q;
      assign tag_o   = tag_q;
      assign data_o  = data_q;
    end else begin : g_comb
      logic unused_s;
      assign unused_s = &{1'b0, clk, reset, adv};
      assign valid_o  = valid_i;
      assign scan_o   = scan_i;
      assign tag_o    = tag_i;
      assign data_o   = mux_s;
    end
  endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux tree with valid/ready handshake, auto-scan channel counter and channel tag.
// Define MUX_TREE_PARITY_EN to add out_par, the XOR of out_data carried through the tree.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int N_IN      = 16,
  parameter int DW        = 1,
  parameter int REG_EVERY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN*DW-1:0]       w,
  input  logic [clog2(N_IN)-1:0]   sel,
  input  logic                     scan_en,
  input  logic                     scan_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            out_data,
  output logic [clog2(N_IN)-1:0]   out_sel,
  output logic                     out_last,
  output logic                     out_valid,
`ifdef MUX_TREE_PARITY_EN
  output logic                     out_par,
`endif
  input  logic                     out_ready
);

  localparam int L = clog2(N_IN);
`ifdef MUX_TREE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int W     = DW + PAR_W;
  localparam int FIN   = (2*N_IN - 2) * W;

  // Level i input words start at (2*N_IN - 2*(N_IN>>i))*W in this packed bus.
  wire [(2*N_IN-1)*W-1:0] bus_s;
  wire [L:0]              valid_s;
  wire [L:0]              scan_s;
  wire [L:0][L-1:0]       tag_s;

  logic         adv_s;
  logic         accept_s;
  logic [L-1:0] eff_sel_s;
  logic [L-1:0] scan_idx_q, scan_idx_d;

  assign adv_s     = !out_valid || out_ready;
  assign in_ready  = adv_s;
  assign accept_s  = in_valid && adv_s;
  assign eff_sel_s = scan_en ? scan_idx_q : sel;

  assign valid_s[0] = in_valid;
  assign scan_s[0]  = scan_en;
  assign tag_s[0]   = eff_sel_s;

  generate
    for (genvar k = 0; k < N_IN; k++) begin : g_chan
`ifdef MUX_TREE_PARITY_EN
      assign bus_s[k*W +: W] = {^w[k*DW +: DW], w[k*DW +: DW]};
`else
      assign bus_s[k*W +: W] = w[k*DW +: DW];
`endif
    end

    for (genvar i = 0; i < L; i++) begin : g_lvl
      localparam int IN_OFF  = (2*N_IN - 2*(N_IN >> i)) * W;
      localparam int OUT_OFF = (2*N_IN - 2*(N_IN >> (i+1))) * W;
      localparam int COUNT   = N_IN >> (i+1);
      localparam bit REG     = (((i+1) % REG_EVERY) == 0) || (i == L-1);

      mux_tree_level #(
        .WIDTH     (W),
        .COUNT     (COUNT),
        .SEL_W     (L),
        .BIT       (i),
        .REGISTERED(REG)
      ) u_level (
        .clk    (clk),
        .reset  (reset),
        .adv    (adv_s),
        .valid_i(valid_s[i]),
        .tag_i  (tag_s[i]),
        .scan_i (scan_s[i]),
        .data_i (bus_s[IN_OFF +: 2*COUNT*W]),
        .valid_o(valid_s[i+1]),
        .tag_o  (tag_s[i+1]),
        .scan_o (scan_s[i+1]),
        .data_o (bus_s[OUT_OFF +: COUNT*W])
      );
    end
  endgenerate

  assign out_data  = bus_s[FIN +: DW];
  assign out_sel   = tag_s[L];
  assign out_valid = valid_s[L];
  assign out_last  = valid_s[L] && scan_s[L] && (tag_s[L] == L'(N_IN-1));
`ifdef MUX_TREE_PARITY_EN
  assign out_par   = bus_s[FIN+DW];
`endif

  // Clear wins over increment; the sample accepted alongside a clear still used the old index.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_clr) begin
      scan_idx_d = '0;
    end else if (accept_s && scan_en) begin
      scan_idx_d = scan_idx_q + L'(1);
    end else begin
      scan_idx_d = scan_idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_idx_q <= '0;
    else       scan_idx_q <= scan_idx_d;
  end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: default 16x1 tree plus an 8x4, REG_EVERY=3 instance.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] w = 16'h0;
  logic [3:0]  sel = 4'h0;
  logic        scan_en = 1'b0, scan_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_last;
  logic [0:0]  out_data;
  logic [3:0]  out_sel;

  logic [31:0] w2 = 32'h0;
  logic [2:0]  sel2 = 3'd0;
  logic        scan_en2 = 1'b0, scan_clr2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic        in_ready2, out_valid2, out_last2;
  logic [3:0]  out_data2;
  logic [2:0]  out_sel2;
`ifdef MUX_TREE_PARITY_EN
  logic        out_par, out_par2;
`endif

  mux_tree_pipe u_dut (
    .clk(clk), .reset(reset), .w(w), .sel(sel), .scan_en(scan_en), .scan_clr(scan_clr),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_last(out_last), .out_valid(out_valid),
`ifdef MUX_TREE_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready)
  );

  mux_tree_pipe #(.N_IN(8), .DW(4), .REG_EVERY(3)) u_dut2 (
    .clk(clk), .reset(reset), .w(w2), .sel(sel2), .scan_en(scan_en2), .scan_clr(scan_clr2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2), .out_sel(out_sel2),
    .out_last(out_last2), .out_valid(out_valid2),
`ifdef MUX_TREE_PARITY_EN
    .out_par(out_par2),
`endif
    .out_ready(out_ready2)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  bit lat_chk = 1'b1;
  logic [3:0] model_idx = 4'd0;

  typedef struct {
    logic       d;
    logic [3:0] s;
    logic       last;
    int         cyc;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare the head entry while valid, pop on handshake, push on acceptance.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] eff;
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q[0];
          check("out_data", {31'd0, out_data}, {31'd0, e.d});
          check("out_sel", {28'd0, out_sel}, {28'd0, e.s});
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef MUX_TREE_PARITY_EN
          check("out_par", {31'd0, out_par}, {31'd0, e.d});
`endif
          if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        eff = scan_en ? model_idx : sel;
        e.d = w[eff];
        e.s = eff;
        e.last = scan_en && (eff == 4'd15);
        e.cyc = cyc;
        q.push_back(e);
      end
      if (scan_clr) model_idx = 4'd0;
      else if (in_valid && in_ready && scan_en) model_idx = model_idx + 4'd1;
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {31'd0, out_data}, 32'd0);
    check("rst_out_sel", {28'd0, out_sel}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid2", {31'd0, out_valid2}, 32'd0);
    check("rst_in_ready2", {31'd0, in_ready2}, 32'd1);
    reset = 1'b0;

    // Manual select sweep, back to back
    w = 16'hA5C3;
    for (int s = 0; s < 16; s++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      sel = 4'(s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Scan mode, 18 consecutive samples
    scan_en = 1'b1;
    in_valid = 1'b1;
    for (int s = 0; s < 18; s++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    scan_en = 1'b0;
    drain();

    // Backpressure mid-stream with changing w
    lat_chk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      sel = 4'($urandom_range(0, 15));
      w = 16'($urandom);
      out_ready = !(i >= 4 && i <= 6);
      #1;
      if (i >= 4 && i <= 6) check("in_ready_stall", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Scan clear alongside an accepted sample at index 7
    w = 16'h0080;
    scan_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    scan_clr = 1'b1;
    @(posedge clk); #1;
    scan_clr = 1'b0;
    w = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scan_en = 1'b0;
    drain();

    // Second instance: latency 1, 4-bit channels
    @(posedge clk); #1;
    w2 = 32'h12B4_5678;
    sel2 = 3'd5;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    sel2 = 3'd2;
    check("d2_valid_a", {31'd0, out_valid2}, 32'd1);
    check("d2_data_a", {28'd0, out_data2}, 32'hB);
    check("d2_sel_a", {29'd0, out_sel2}, 32'd5);
    check("d2_last_a", {31'd0, out_last2}, 32'd0);
`ifdef MUX_TREE_PARITY_EN
    check("d2_par_a", {31'd0, out_par2}, 32'd1);
`endif
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("d2_data_b", {28'd0, out_data2}, 32'h6);
    check("d2_sel_b", {29'd0, out_sel2}, 32'd2);
`ifdef MUX_TREE_PARITY_EN
    check("d2_par_b", {31'd0, out_par2}, 32'd0);
`endif
    @(posedge clk); #1;
    check("d2_idle", {31'd0, out_valid2}, 32'd0);

    // Asynchronous reset with two samples in flight
    @(posedge clk); #1;
    w = 16'hFFFF;
    scan_en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    model_idx = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scan_en = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
Parametrised, pipelined N_IN-to-1 multiplexer tree that replaces the fixed 16:1 two-level mux.
- Generalises channel count and per-channel data width.
- Registers the tree at a configurable level spacing.
- Adds a valid/ready handshake, an auto-scan mode that steps through channels, and a channel tag carried alongside the data.
- Sits between a bank of sampled inputs and a single serial consumer.

Parameters:
N_IN, 16, number of input channels; power of 2, at least 2.
DW, 1, data width per channel.
REG_EVERY, 2, a pipeline register follows every REG_EVERY tree levels; the final level is always registered.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
w  in  N_IN*DW  channel data, flattened; channel k occupies bits [k*DW +: DW]
sel  in  log2(N_IN)  manual channel select, used when scan_en=0
scan_en  in  1  1 selects the channel from the internal scan counter
scan_clr  in  1  synchronous clear of the scan counter
in_valid  in  1  the sample on w/sel is offered
in_ready  out  1  the pipeline accepts this cycle
out_data  out  DW  selected channel data
out_sel  out  log2(N_IN)  index of the channel in out_data
out_last  out  1  out_sel == N_IN-1 and the sample came from scan mode
out_valid  out  1  out_data, out_sel and out_last are valid
out_ready  in  1  the consumer accepts this cycle

Behaviour:
- Clock and reset: already decided; one clock (clk); reset is asynchronous and active-high (reset).
- Geometry: L = log2(N_IN) levels of 2:1 muxes. Level i uses bit i of the effective select (LSB first).
- Latency: a register follows level i when (i+1) % REG_EVERY == 0 or i == L-1. Latency is ceil(L/REG_EVERY) cycles from acceptance to out_valid.
  - Defaults: L=4, latency 2.
  - REG_EVERY >= L gives latency 1.
- Effective select: eff_sel = scan_en ? scan_idx : sel. It is sampled at acceptance and travels through the stages with the data.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together when adv=1. Bubbles are not collapsed.
- Valid bits: each stage has one valid bit. Stage 0 loads in_valid when adv=1. Every stage holds data, tag and valid when adv=0.
- Acceptance: a sample is accepted when in_valid && in_ready.
- Scan counter (scan_idx):
  - Width log2(N_IN); reset value 0.
  - Increments by 1 on each accepted sample while scan_en=1.
  - Wraps from N_IN-1 to 0.
  - Holds its value while scan_en=0.
  - scan_clr=1 forces it to 0 on the next edge and takes priority over an increment in the same cycle. The sample accepted in that cycle still uses the old scan_idx.
- out_last: asserted with a sample whose tag is N_IN-1 and which was accepted with scan_en=1. The scan-mode flag travels with the tag.
- Reset (asynchronous): all valid bits, out_data, out_sel, out_last and scan_idx go to 0. Reset mid-flight discards in-flight samples. in_ready reads 1 directly after reset.
- Input stability: w may change every cycle; only the value at acceptance matters. No combinational path from w to outputs.

Optional Feature:
- Macro: MUX_TREE_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit), equal to the XOR of out_data bits.
  - out_par is registered in the final stage, aligned with out_valid, and resets to 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Package mux_tree_pkg holds:
  - a clog2 function;
  - SEL_W derived from N_IN;
  - a localparam computing latency from L and REG_EVERY.
- Sub-module mux_tree_level: one tree level of N/2 2:1 muxes.
  - Parameters: width, count, REGISTERED.
  - Carries valid, tag and the scan-mode flag alongside the data.
  - The top instantiates L copies of it in a generate loop.

Test Plan:
- Manual select, N_IN=16, DW=1, w=16'hA5C3, out_ready=1: offer sel=0..15 back to back -> out_data follows the bits of w at sel, out_sel=0..15, first out_valid 2 cycles after the first acceptance, one output per cycle.
- Scan mode, scan_en=1, in_valid held high for 18 cycles -> out_sel runs 0..15,0,1; out_last=1 only on the sample with out_sel=15.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready=0 those cycles; out_data/out_sel hold; no sample lost or duplicated; order preserved.
- scan_clr together with an accepted sample at scan_idx=7 -> that sample tagged 7; the next accepted sample tagged 0.
- Assert reset mid-stream with 2 samples in flight -> out_valid=0 immediately (asynchronous), scan_idx=0, in_ready=1 after release; no stale output appears.
- N_IN=8, DW=4, REG_EVERY=3, with MUX_TREE_PARITY_EN -> latency 1; out_par = XOR of out_data bits for channel data 4'b1011 (out_par=1).
